// File: rtl/hex_keypad_if.sv
// Keypad-side and result-side signals of the hex keypad scanner.
// The slave modport is the scanner, and the master modport is the keypad/consumer.
interface hex_keypad_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: one-hot active-low column drive and a synchronized row read.
// Presses and releases are debounced, and each accepted press gives one key_valid strobe.
module hex_keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic   clock,
    input  logic   reset_n,
    hex_keypad_if.slave kp
);

    localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       pattern;
    logic [3:0]       rows_meta;
    logic [3:0]       rs;
    logic [3:0]       cols_q;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;

    assign kp.cols      = cols_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Lowest-index low row in the latched pattern wins within the held column.
    function automatic logic [3:0] map_key(input logic [3:0] pat, input logic [1:0] c);
        logic [1:0] r;
        if (!pat[0])      r = 2'd0;
        else if (!pat[1]) r = 2'd1;
        else if (!pat[2]) r = 2'd2;
        else              r = 2'd3;
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'h0;
            4'b11_01: return 4'hF;
            4'b11_10: return 4'hE;
            default:  return 4'hD;
        endcase
    endfunction

    // NOTE: synchronizer resets to all-ones (no key) so release from reset never sees a phantom press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rows_meta <= 4'hF;
            rs        <= 4'hF;
        end else begin
            rows_meta <= kp.rows;
            rs        <= rows_meta;
        end
    end

    // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            cnt         <= '0;
            pattern     <= 4'hF;
            cols_q      <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (rs == 4'hF) begin
                            col_idx <= col_idx + 2'd1;
                            cols_q  <= col_drive(col_idx + 2'd1);
                        end else begin
                            pattern <= rs;
                            state   <= DEBOUNCE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DEBOUNCE: begin
                    if (rs != pattern) begin
                        state <= SCAN;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        key_code_q  <= map_key(pattern, col_idx);
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                PRESSED: begin
                    key_valid_q <= 1'b0;
                    cnt         <= '0;
                    state       <= RELEASE;
                end

                RELEASE: begin
                    // Any row activity on the held column restarts the release count.
                    if (rs != 4'hF) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        key_held_q <= 1'b0;
                        col_idx    <= col_idx + 2'd1;
                        cols_q     <= col_drive(col_idx + 2'd1);
                        cnt        <= '0;
                        state      <= SCAN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
// A small keypad model shorts rows to the driven column for every pressed key.
module tb_hex_keypad_scanner;

    logic clock;
    logic reset_n;
    hex_keypad_if kp ();

    hex_keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .kp      (kp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] keys;  // bit r*4+c set = key at (row r, col c) pressed
    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    logic [3:0] last_code = 4'h0;

    always_comb begin
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (keys[ri*4+ci] && !kp.cols[ci]) r[ri] = 1'b0;
        kp.rows = r;
    end

    always @(negedge clock) begin
        if (kp.key_valid) begin
            pulse_cnt <= pulse_cnt + 1;
            last_code <= kp.key_code;
        end
    end

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] one;
        one = 16'd1;
        return one << (r * 4 + c);
    endfunction

    function automatic logic [3:0] col_exp(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic wait_valid(input int max, output bit ok);
        int base;
        base = pulse_cnt;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (pulse_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (!kp.key_held) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cols(input logic [3:0] val, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (kp.cols == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        bit   ok;
        int   base;

        vecs[0] = '{row: 0, col: 0, code: 4'h1};
        vecs[1] = '{row: 3, col: 3, code: 4'hD};
        vecs[2] = '{row: 2, col: 1, code: 4'h8};
        vecs[3] = '{row: 3, col: 0, code: 4'h0};
        vecs[4] = '{row: 1, col: 3, code: 4'hB};

        // Reset and idle column rotation
        keys    = 16'h0;
        reset_n = 1'b0;
        step(2);
        check("reset_cols", 32'(kp.cols), 32'(4'b1110));
        check("reset_code", 32'(kp.key_code), 32'h0);
        check("reset_valid", 32'(kp.key_valid), 32'h0);
        check("reset_held", 32'(kp.key_held), 32'h0);
        reset_n = 1'b1;
        check("idle_cols_k0", 32'(kp.cols), 32'(4'b1110));
        for (int k = 1; k < 40; k++) begin
            step(1);
            check($sformatf("idle_cols_k%0d", k), 32'(kp.cols), 32'(col_exp((k / 4) % 4)));
        end
        check("idle_no_pulse", 32'(pulse_cnt), 32'd0);
        check("idle_code", 32'(kp.key_code), 32'h0);

        // Key 6 (row1/col2) with exact release timing
        keys = key_bit(1, 2);
        wait_valid(100, ok);
        check("k6_seen", 32'(ok), 32'd1);
        check("k6_code", 32'(kp.key_code), 32'h6);
        check("k6_held", 32'(kp.key_held), 32'd1);
        step(1);
        check("k6_pulse_width", 32'(kp.key_valid), 32'd0);
        step(20);
        check("k6_single_pulse", 32'(pulse_cnt), 32'd1);
        check("k6_cols_hold", 32'(kp.cols), 32'(4'b1011));
        check("k6_held_hold", 32'(kp.key_held), 32'd1);
        keys = 16'h0;
        step(9);
        check("k6_held_rel9", 32'(kp.key_held), 32'd1);
        step(1);
        check("k6_held_rel10", 32'(kp.key_held), 32'd0);
        check("k6_cols_next", 32'(kp.cols), 32'(4'b0111));

        // Table of single-key presses
        foreach (vecs[i]) begin
            base = pulse_cnt;
            keys = key_bit(vecs[i].row, vecs[i].col);
            wait_valid(100, ok);
            check($sformatf("vec%0d_seen", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_code", i), 32'(kp.key_code), 32'(vecs[i].code));
            check($sformatf("vec%0d_cols", i), 32'(kp.cols), 32'(col_exp(vecs[i].col)));
            step(1);
            check($sformatf("vec%0d_pulse_width", i), 32'(kp.key_valid), 32'd0);
            keys = 16'h0;
            wait_held_low(40, ok);
            check($sformatf("vec%0d_released", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_cols_next", i), 32'(kp.cols), 32'(col_exp((vecs[i].col + 1) % 4)));
            check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt), 32'(base + 1));
        end

        // Key F (row3/col1) with a 3-cycle bounce during debounce
        wait_cols(4'b1101, 40, ok);
        check("bounce_col1", 32'(ok), 32'd1);
        base = pulse_cnt;
        keys = key_bit(3, 1);
        step(5);
        keys = 16'h0;
        step(3);
        keys = key_bit(3, 1);
        check("bounce_no_pulse", 32'(pulse_cnt), 32'(base));
        wait_valid(40, ok);
        check("bounce_seen", 32'(ok), 32'd1);
        check("bounce_code", 32'(kp.key_code), 32'hF);
        step(20);
        check("bounce_single", 32'(pulse_cnt), 32'(base + 1));
        keys = 16'h0;
        wait_held_low(40, ok);
        check("bounce_released", 32'(ok), 32'd1);

        // Two rows in col3, a col0 key added while held, then chattering release
        base = pulse_cnt;
        keys = key_bit(0, 3) | key_bit(2, 3);
        wait_valid(100, ok);
        check("multi_seen", 32'(ok), 32'd1);
        check("multi_code", 32'(kp.key_code), 32'hA);
        step(1);
        keys = keys | key_bit(1, 0);
        step(30);
        check("multi_no_rollover", 32'(pulse_cnt), 32'(base + 1));
        check("multi_held", 32'(kp.key_held), 32'd1);
        check("multi_cols", 32'(kp.cols), 32'(4'b0111));
        keys = key_bit(0, 3) | key_bit(2, 3);
        step(2);
        keys = 16'h0;
        step(2);
        keys = key_bit(0, 3) | key_bit(2, 3);
        step(2);
        keys = 16'h0;
        step(9);
        check("chatter_held9", 32'(kp.key_held), 32'd1);
        step(1);
        check("chatter_held10", 32'(kp.key_held), 32'd0);
        check("chatter_no_pulse", 32'(pulse_cnt), 32'(base + 1));

        // Reset during debounce of key 7 (row2/col0), key kept held
        wait_cols(4'b1110, 40, ok);
        check("rst_col0", 32'(ok), 32'd1);
        keys = key_bit(2, 0);
        step(5);
        base = pulse_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_cols", 32'(kp.cols), 32'(4'b1110));
        check("rst_async_code", 32'(kp.key_code), 32'h0);
        check("rst_async_valid", 32'(kp.key_valid), 32'd0);
        check("rst_async_held", 32'(kp.key_held), 32'd0);
        step(2);
        reset_n = 1'b1;
        check("rst_no_pulse", 32'(pulse_cnt), 32'(base));
        wait_valid(60, ok);
        check("rst_redetect", 32'(ok), 32'd1);
        check("rst_code", 32'(kp.key_code), 32'h7);
        step(20);
        check("rst_single", 32'(pulse_cnt), 32'(base + 1));
        keys = 16'h0;
        wait_held_low(40, ok);
        check("rst_released", 32'(ok), 32'd1);
        check("last_code", 32'(last_code), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
- Scans a 4x4 hex keypad and returns the debounced hex code of the pressed key.
- It is the input-side counterpart to the board's scanned seven-segment output path: it drives one-hot active-low column selects and reads active-low row returns.
- Output feeds downstream logic as a 4-bit value plus a one-cycle strobe, for example to the hex display or a register load.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is held active before rows are sampled (settling time); minimum 4.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a press or a release; minimum 2.

Ports:
- clock  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rows  input  4  keypad row returns, active-low (pulled up externally), asynchronous to clock
- cols  output  4  column drive, active-low one-hot; exactly one bit low at all times
- key_code  output  4  hex value of the last accepted key; holds until the next press
- key_valid  output  1  one-cycle pulse when a new debounced press is accepted
- key_held  output  1  high from acceptance until the debounced release completes

Behaviour:
- Reset, asynchronous assert, synchronous release:
  - cols = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0.
  - State = SCAN, column index = 0, counters = 0, synchronizer flops = 4'b1111.
- rows passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- Key map, (row,col) -> code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- SCAN:
  - cols drives the current column low; the counter runs 0..SCAN_DIV-1.
  - At count == SCAN_DIV-1, sample rs:
    - rs == 4'hF: advance the column index (3 wraps to 0) and clear the counter.
    - Otherwise: latch rs as the pattern and go to DEBOUNCE with the column held and the counter cleared.
- DEBOUNCE:
  - Column held; each cycle compare rs to the latched pattern.
  - Mismatch: return to SCAN on the same column with the counter cleared; no output change.
  - Match for DEBOUNCE_CYCLES consecutive cycles: go to PRESSED.
- PRESSED, exactly one cycle:
  - key_code <= map(lowest-index low row in pattern, column).
  - key_valid = 1, key_held <= 1; go to RELEASE.
- RELEASE:
  - Column held; the counter clears on any cycle with rs != 4'hF.
  - After DEBOUNCE_CYCLES consecutive cycles of rs == 4'hF: key_held <= 0, advance the column, clear the counter, go to SCAN.
- Outputs are registered. key_valid rises on the clock edge that enters PRESSED and falls on the next edge.
- Multiple keys:
  - Only the current column is examined.
  - Within that column the lowest row index wins.
  - Keys in other columns are ignored until RELEASE completes.
  - No rollover: a second key pressed while one is held produces no key_valid.
- Re-press of the same key requires a full debounced release first; each accepted press gives exactly one key_valid.
- Reset mid-press or mid-debounce:
  - All state returns to reset values immediately; no key_valid.
  - A key still held after reset is re-detected and reported once after a full scan and debounce.
- A glitch shorter than DEBOUNCE_CYCLES never produces key_valid, in either press or release.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset, then no keys for 40 cycles:
  - cols cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held 4 cycles.
  - key_valid never asserts; key_code = 0.
- Hold row1 low whenever col2 is driven, stable:
  - Exactly one key_valid pulse with key_code = 4'h6.
  - key_held stays high and cols stays 1011 until rows are released.
  - After release plus 8 cycles, key_held = 0 and cols = 0111.
- Press the row3/col1 key with a 3-cycle bounce at onset:
  - The bounce restarts DEBOUNCE with no pulse.
  - After stable contact, one key_valid with key_code = 4'hF.
- Hold row0 and row2 low together in col3:
  - key_code = 4'hA, single pulse.
  - Adding a col0 key while held produces no further pulse.
- Release with 2-cycle chatter (rows go high, then low, then high):
  - key_held stays 1 until 8 clean high cycles.
  - No second key_valid is produced.
- Assert reset_n = 0 during DEBOUNCE:
  - Outputs return to reset values asynchronously.
  - Keeping the key (row2/col0) held afterward yields one key_valid with key_code = 4'h7.
